// File: rtl/align_s2p_hs.sv
// Narrow-to-wide stream aligner: packs REG_NUM input beats LSB-first into one word, with valid/ready on both sides.
// Build option ALIGN_ZERO_PAD_EN: zero the unwritten lanes of a loaded word instead of leaving stale contents.
module align_s2p_hs #(
  parameter int unsigned IDATA_WIDTH = 64,
  parameter int unsigned ODATA_BIT   = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IDATA_WIDTH-1:0]               idata,
  input  logic                                 idata_valid,
  output logic                                 idata_ready,
  input  logic                                 idata_last,
  output logic [ODATA_BIT-1:0]                 odata,
  output logic                                 odata_valid,
  input  logic                                 odata_ready,
  output logic [ODATA_BIT/IDATA_WIDTH-1:0]     odata_keep,
  output logic                                 odata_last
);

  localparam int unsigned REG_NUM  = ODATA_BIT / IDATA_WIDTH;
  localparam int unsigned ADDR_BIT = $clog2(REG_NUM);
  localparam logic [ADDR_BIT-1:0] LAST_LANE = ADDR_BIT'(REG_NUM - 1);

  logic [ODATA_BIT-1:0] acc_q, acc_d;
  logic [REG_NUM-1:0]   keep_q, keep_d;
  logic [ADDR_BIT-1:0]  wptr_q, wptr_d;
  logic                 acc_full_q, acc_full_d;
  logic                 acc_last_q, acc_last_d;
  logic [ODATA_BIT-1:0] odata_q, odata_d;
  logic [REG_NUM-1:0]   okeep_q, okeep_d;
  logic                 olast_q, olast_d;
  logic                 ovalid_q, ovalid_d;

  logic [ODATA_BIT-1:0] new_data, src_data, load_data;
  logic [REG_NUM-1:0]   new_keep, src_keep;
  logic                 src_last;
  logic                 in_fire, out_fire, out_free, close, load;

  // Accumulator contents with the current beat merged into lane wptr.
  always_comb begin
    new_data = acc_q;
    new_keep = keep_q;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (wptr_q == ADDR_BIT'(i)) begin
        new_data[i*IDATA_WIDTH +: IDATA_WIDTH] = idata;
        new_keep[i] = 1'b1;
      end
    end
  end

  // A stalled word drains from the accumulator; otherwise the closing beat's word loads directly.
  always_comb begin
    src_data  = acc_full_q ? acc_q      : new_data;
    src_keep  = acc_full_q ? keep_q     : new_keep;
    src_last  = acc_full_q ? acc_last_q : idata_last;
    load_data = src_data;
`ifdef ALIGN_ZERO_PAD_EN
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (!src_keep[i]) load_data[i*IDATA_WIDTH +: IDATA_WIDTH] = '0;
    end
`endif
  end

  always_comb begin
    acc_d      = acc_q;
    keep_d     = keep_q;
    wptr_d     = wptr_q;
    acc_full_d = acc_full_q;
    acc_last_d = acc_last_q;
    odata_d    = odata_q;
    okeep_d    = okeep_q;
    olast_d    = olast_q;
    ovalid_d   = ovalid_q;
    load       = 1'b0;

    in_fire  = idata_valid && !acc_full_q;
    out_fire = ovalid_q && odata_ready;
    out_free = !ovalid_q || odata_ready;
    close    = in_fire && ((wptr_q == LAST_LANE) || idata_last);

    if (out_fire) ovalid_d = 1'b0;

    if (acc_full_q) begin
      if (out_fire) begin
        load       = 1'b1;
        acc_full_d = 1'b0;
        acc_last_d = 1'b0;
        wptr_d     = '0;
        keep_d     = '0;
      end
    end else if (in_fire) begin
      acc_d = new_data;
      if (close) begin
        if (out_free) begin
          load   = 1'b1;
          wptr_d = '0;
          keep_d = '0;
        end else begin
          keep_d     = new_keep;
          acc_last_d = idata_last;
          acc_full_d = 1'b1;
        end
      end else begin
        keep_d = new_keep;
        wptr_d = (wptr_q == LAST_LANE) ? '0 : ADDR_BIT'(wptr_q + 1'b1);
      end
    end

    if (load) begin
      odata_d  = load_data;
      okeep_d  = src_keep;
      olast_d  = src_last;
      ovalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      keep_q     <= '0;
      wptr_q     <= '0;
      acc_full_q <= 1'b0;
      acc_last_q <= 1'b0;
      odata_q    <= '0;
      okeep_q    <= '0;
      olast_q    <= 1'b0;
      ovalid_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      keep_q     <= keep_d;
      wptr_q     <= wptr_d;
      acc_full_q <= acc_full_d;
      acc_last_q <= acc_last_d;
      odata_q    <= odata_d;
      okeep_q    <= okeep_d;
      olast_q    <= olast_d;
      ovalid_q   <= ovalid_d;
    end
  end

  assign idata_ready = !acc_full_q;
  assign odata       = odata_q;
  assign odata_keep  = okeep_q;
  assign odata_last  = olast_q;
  assign odata_valid = ovalid_q;

endmodule

// File: tb/tb_align_s2p_hs.sv
// Scoreboard bench for align_s2p_hs: directed cases plus randomized valid/ready traffic against a word-level model.
module tb_align_s2p_hs;

  localparam int unsigned IW = 64;
  localparam int unsigned OW = 256;
  localparam int unsigned RN = OW / IW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] idata;
  logic          idata_valid;
  logic          idata_ready;
  logic          idata_last;
  logic [OW-1:0] odata;
  logic          odata_valid;
  logic          odata_ready;
  logic [RN-1:0] odata_keep;
  logic          odata_last;

  align_s2p_hs #(.IDATA_WIDTH(IW), .ODATA_BIT(OW)) dut (
    .clk(clk), .rst(rst),
    .idata(idata), .idata_valid(idata_valid), .idata_ready(idata_ready), .idata_last(idata_last),
    .odata(odata), .odata_valid(odata_valid), .odata_ready(odata_ready),
    .odata_keep(odata_keep), .odata_last(odata_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [RN-1:0] keep;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [IW-1:0] cur_beats[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a word is whatever beats were accepted since the last close, lane i = i-th beat.
  function automatic void close_word(input logic last);
    word_t w;
    w.data = '0;
    w.keep = '0;
    foreach (cur_beats[i]) begin
      w.data[i*IW +: IW] = cur_beats[i];
      w.keep[i]          = 1'b1;
    end
    w.last = last;
    exp_q.push_back(w);
    cur_beats.delete();
  endfunction

  function automatic logic [OW-1:0] lane_mask(input logic [RN-1:0] keep);
    logic [OW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(RN); i++) begin
`ifdef ALIGN_ZERO_PAD_EN
      m[i*IW +: IW] = '1;
`else
      if (keep[i]) m[i*IW +: IW] = '1;
`endif
    end
    return m;
  endfunction

  // Monitor: stability under stall, output-word scoreboard, then record accepted input beats.
  logic  stall_prev = 1'b0;
  word_t held;
  always @(negedge clk) begin
    word_t         w;
    logic [OW-1:0] m;
    if (rst) begin
      exp_q.delete();
      cur_beats.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", OW'(odata_valid), OW'(1'b1));
        check("stall_word", OW'({odata, odata_keep, odata_last}), OW'(held));
      end
      if (odata_valid && odata_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected none", odata);
        end else begin
          w = exp_q.pop_front();
          m = lane_mask(w.keep);
          check("word_data", odata & m, w.data & m);
          check("word_keep", OW'(odata_keep), OW'(w.keep));
          check("word_last", OW'(odata_last), OW'(w.last));
        end
      end
      stall_prev = odata_valid && !odata_ready;
      held       = {odata, odata_keep, odata_last};
      if (idata_valid && idata_ready) begin
        cur_beats.push_back(idata);
        if (idata_last || cur_beats.size() == int'(RN)) close_word(idata_last);
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded wait); returns at the drive point after acceptance.
  task automatic send(input logic [IW-1:0] d, input logic l);
    int t;
    t           = 0;
    idata       = d;
    idata_last  = l;
    idata_valid = 1'b1;
    @(negedge clk);
    while (!idata_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!idata_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got idata_ready=0 expected 1 within 200 cycles");
    end
    to_drive();
    idata_valid = 1'b0;
    idata_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", OW'(odata_valid), '0);
    check("rst_keep", OW'(odata_keep), '0);
    check("rst_data", odata, '0);
    check("rst_iready", OW'(idata_ready), OW'(1'b1));
    to_drive();
  endtask

  initial begin
    logic [OW-1:0] e2;
    int            sent;
    int            cyc;
    logic          fired;
    rst         = 1'b1;
    idata       = '0;
    idata_valid = 1'b0;
    idata_last  = 1'b0;
    odata_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("init_valid", OW'(odata_valid), '0);
    check("init_iready", OW'(idata_ready), OW'(1'b1));
    check("init_data", odata, '0);
    check("init_keep", OW'(odata_keep), '0);
    to_drive();

    // Four back-to-back beats, word visible the cycle after the fourth, for one cycle
    odata_ready = 1'b1;
    send(64'h11, 1'b0);
    send(64'h22, 1'b0);
    send(64'h33, 1'b0);
    send(64'h44, 1'b0);
    e2 = {64'h44, 64'h33, 64'h22, 64'h11};
    @(negedge clk);
    check("full_valid", OW'(odata_valid), OW'(1'b1));
    check("full_data", odata, e2);
    check("full_keep", OW'(odata_keep), OW'(4'b1111));
    check("full_last", OW'(odata_last), '0);
    @(negedge clk);
    check("full_valid_drop", OW'(odata_valid), '0);
    to_drive();

    // Early flush on idata_last
    send(64'hA, 1'b0);
    send(64'hB, 1'b1);
    @(negedge clk);
    check("part_keep", OW'(odata_keep), OW'(4'b0011));
    check("part_last", OW'(odata_last), OW'(1'b1));
    to_drive();

    // Backpressure: second word parks in the accumulator, then drains with no gap
    odata_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(IW'(32'h100 + i), 1'b0);
    @(negedge clk);
    check("bp_iready", OW'(idata_ready), '0);
    check("bp_valid", OW'(odata_valid), OW'(1'b1));
    to_drive();
    odata_ready = 1'b1;
    @(negedge clk);
    check("bp_fire1", OW'(odata_valid), OW'(1'b1));
    @(negedge clk);
    check("bp_fire2", OW'(odata_valid), OW'(1'b1));
    check("bp_iready_back", OW'(idata_ready), OW'(1'b1));
    to_drive();

    // Randomized traffic
    sent  = 0;
    cyc   = 0;
    fired = 1'b0;
    while (sent < 1000 && cyc < 30000) begin
      if (!idata_valid || fired) begin
        idata_valid = ($urandom_range(0, 3) != 0);
        idata       = {$urandom, $urandom};
        idata_last  = ($urandom_range(0, 5) == 0);
      end
      odata_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = idata_valid && idata_ready;
      if (fired) sent++;
      to_drive();
      cyc++;
    end
    idata_valid = 1'b0;
    idata_last  = 1'b0;
    check("rand_beats", OW'(sent), OW'(1000));
    send({$urandom, $urandom}, 1'b1);
    odata_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rand_drained", OW'(exp_q.size()), '0);
    to_drive();

    // Reset mid-word, then a clean word
    send(64'hD1, 1'b0);
    send(64'hD2, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) send(IW'(32'hE0 + i), 1'b0);
    @(negedge clk);
    check("mid_rst_keep", OW'(odata_keep), OW'(4'b1111));
    to_drive();

    // Reset during an acc_full stall, then a clean word
    odata_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(IW'(32'hF0 + i), 1'b0);
    pulse_reset();
    odata_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(IW'(32'hC0 + i), 1'b0);
    @(negedge clk);
    check("stall_rst_keep", OW'(odata_keep), OW'(4'b1111));
    repeat (3) @(negedge clk);
    check("final_drained", OW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
